multi_resistor_measure: RTL
===========================

// Module: multi_resistor_measure
// PURPOSE
// Parametrised, multi-channel capacitor-charge-time sensor for paddle potentiometers.
// One shared drain/measure cycle serves NUM_CH channels. Each channel debounces its comparator input,
// captures the charge time and averages 2^AVG_LOG2 periods before publishing a value.
// Sits between the paddle pins (hysteresis inputs) and the game logic.
// PARAMETERS
// NUM_CH    2   number of sensed channels
// CNT_W     16  phase-counter width; MEASURE=2^(CNT_W-1) cycles, DRAIN=2^(CNT_W-2) cycles
// VALUE_W   8   published sample width; VALUE_W <= CNT_W-1
// DEBOUNCE  5   consecutive synchronised highs required to capture (>=1)
// AVG_LOG2  2   log2 of periods averaged per published value (0 = no averaging)
// PORTS
// clk                in   1               system clock
// reset              in   1               synchronous, active-high reset
// measure            in   NUM_CH          raw comparator input per channel, asynchronous
// drain_capacitance  out  1               1 = discharge all capacitors
// value              out  NUM_CH*VALUE_W  averaged sample; channel i at [i*VALUE_W +: VALUE_W]
// timeout            out  NUM_CH          1 = at least one period in the last batch never captured
// value_valid        out  1               1-cycle pulse: value/timeout updated
// BEHAVIOUR
// - Reset (sync, high): phase=DRAIN, cnt=0, drain_capacitance=1, value=0, timeout=0, value_valid=0.
//   Synchronisers, debounce counters, accumulators and period counter all cleared.
//   Reset mid-operation aborts the batch; the next valid comes only after 2^AVG_LOG2 complete periods.
// - Phase FSM: DRAIN (D=2^(CNT_W-2) cycles) -> MEASURE (M=2^(CNT_W-1) cycles) -> DRAIN.
//   cnt counts 0..len-1 in each phase and clears on the transition.
// - drain_capacitance is registered: 1 in every DRAIN cycle, 0 in every MEASURE cycle.
// - measure[i] passes a 2-FF synchroniser (reset 0). Debounce and capture use only the synchronised bit s[i].
//   No latency compensation is applied.
// - Per channel in MEASURE, while not yet locked:
//   - s=1 increments the run counter; s=0 clears it.
//   - When the run counter reaches DEBOUNCE: raw = cnt[CNT_W-2 -: VALUE_W] of that cycle, and the channel locks.
//   - Locked channels ignore s until the next MEASURE.
// - Entering MEASURE: raw preset to all-ones (2^VALUE_W-1); run counter cleared; lock cleared.
//   A channel that never locks keeps raw=max and sets its sticky batch-timeout bit.
// - A capture in cycle M-1 still counts for that period.
// - On cycle M-1 of MEASURE: acc += raw (acc width VALUE_W+AVG_LOG2, no overflow possible); period count increments.
// - On the 2^AVG_LOG2-th period:
//   - value <= (acc+raw)>>AVG_LOG2 and timeout <= sticky|this-period-timeout, both registered.
//   - value_valid=1 on the first DRAIN cycle.
//   - acc, sticky and period count clear in the same edge.
// - value/timeout hold between pulses. All channels update together under one value_valid.
// STRUCTURE
// - Package resistor_measure_pkg: typedef enum logic {PH_DRAIN, PH_MEASURE} phase_e.
// - Sub-module measure_channel: synchroniser, debounce, lock, raw, acc, sticky timeout.
//   Instantiated NUM_CH times in a generate loop.
// - Top holds phase FSM, cnt, period counter and the shared commit strobe.
// TESTING (CNT_W=6 -> D=16, M=32; VALUE_W=4 -> raw=cnt[4:1]; DEBOUNCE=3; AVG_LOG2=1; NUM_CH=2)
// - Reset release -> drain=1 for 16 cycles, then 0 for 32, repeating.
//   No value_valid before the end of the 2nd MEASURE.
// - measure[0] rises at MEASURE cnt 10 and holds, two periods:
//   - s high at cnt 12, lock at cnt 14 -> raw 7.
//   - value[3:0]=7, timeout[0]=0, one value_valid pulse on first DRAIN cycle.
// - measure[1] held 0 -> value[7:4]=15, timeout[1]=1. Channel 0 unaffected.
// - Glitch: measure[0] high cnt 10-11, low, high from cnt 20 -> lock at cnt 24 -> raw 12.
//   Held high in DRAIN has no effect.
// - Averaging: period A raw 7, period B raw 12 -> value=(7+12)>>1=9.
//   Lock at cnt 31 (last cycle) -> raw 15 with timeout=0.
// - Reset asserted mid-MEASURE -> drain=1 next cycle, outputs zeroed.
//   First valid only after 2 full post-reset periods.

Source files
------------

// File: rtl/resistor_measure_pkg.sv
// rtl/resistor_measure_pkg.sv - shared types for the paddle charge-time sensor
package resistor_measure_pkg;

    typedef enum logic {
        PH_DRAIN,
        PH_MEASURE
    } phase_e;

endpackage

// File: rtl/measure_channel.sv
// rtl/measure_channel.sv - one sensed channel: synchroniser, debounce/lock, capture, averaging
module measure_channel
    import resistor_measure_pkg::*;
#(
    parameter int VALUE_W  = 8,
    parameter int DEBOUNCE = 5,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               measure_i,
    input  logic               meas_active_i,
    input  logic               start_i,
    input  logic               last_i,
    input  logic               commit_i,
    input  logic [VALUE_W-1:0] raw_sample_i,
    output logic [VALUE_W-1:0] value_o,
    output logic               timeout_o
);

    localparam int RUN_W = $clog2(DEBOUNCE + 1);
    localparam int ACC_W = VALUE_W + AVG_LOG2;

    logic               sync1_q, s_q;
    logic [RUN_W-1:0]   run_q, run_d, run_inc;
    logic               locked_q, locked_d, locked_eff;
    logic [VALUE_W-1:0] raw_q, raw_d, raw_eff;
    logic [ACC_W-1:0]   acc_q, acc_d, sum;
    logic               sticky_q, sticky_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               timeout_q, timeout_d;
    logic               capture;

    always_comb begin
        run_inc    = run_q + 1'b1;
        capture    = meas_active_i && !locked_q && s_q && (run_inc == RUN_W'(DEBOUNCE));
        // A capture on the final MEASURE cycle must still reach this period's accumulate.
        raw_eff    = capture ? raw_sample_i : raw_q;
        locked_eff = locked_q | capture;
        sum        = acc_q + ACC_W'(raw_eff);

        run_d     = run_q;
        locked_d  = locked_q;
        raw_d     = raw_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        value_d   = value_q;
        timeout_d = timeout_q;

        if (start_i) begin
            run_d    = '0;
            locked_d = 1'b0;
            raw_d    = '1;
        end else if (meas_active_i && !locked_q) begin
            run_d = s_q ? run_inc : '0;
            if (capture) begin
                locked_d = 1'b1;
                raw_d    = raw_sample_i;
            end
        end

        if (last_i) begin
            if (commit_i) begin
                value_d   = VALUE_W'(sum >> AVG_LOG2);
                timeout_d = sticky_q | !locked_eff;
                acc_d     = '0;
                sticky_d  = 1'b0;
            end else begin
                acc_d    = sum;
                sticky_d = sticky_q | !locked_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            run_q     <= '0;
            locked_q  <= 1'b0;
            raw_q     <= '1;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            value_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync1_q   <= measure_i;
            s_q       <= sync1_q;
            run_q     <= run_d;
            locked_q  <= locked_d;
            raw_q     <= raw_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            value_q   <= value_d;
            timeout_q <= timeout_d;
        end
    end

    assign value_o   = value_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/multi_resistor_measure.sv
// rtl/multi_resistor_measure.sv - shared drain/measure sequencer for NUM_CH paddle channels
module multi_resistor_measure
    import resistor_measure_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int VALUE_W  = 8,
    parameter int DEBOUNCE = 5,
    parameter int AVG_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         measure,
    output logic                      drain_capacitance,
    output logic [NUM_CH*VALUE_W-1:0] value,
    output logic [NUM_CH-1:0]         timeout,
    output logic                      value_valid
);

    localparam logic [CNT_W-1:0]  D_LAST      = CNT_W'((1 << (CNT_W - 2)) - 1);
    localparam logic [CNT_W-1:0]  M_LAST      = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [AVG_LOG2:0] PERIOD_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AVG_LOG2:0]  period_q, period_d;
    logic               drain_q, valid_q;
    logic               start_meas, last_meas, commit;

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q + 1'b1;
        start_meas = 1'b0;
        last_meas  = 1'b0;
        case (phase_q)
            PH_DRAIN: begin
                if (cnt_q == D_LAST) begin
                    phase_d    = PH_MEASURE;
                    cnt_d      = '0;
                    start_meas = 1'b1;
                end
            end
            PH_MEASURE: begin
                if (cnt_q == M_LAST) begin
                    phase_d   = PH_DRAIN;
                    cnt_d     = '0;
                    last_meas = 1'b1;
                end
            end
            default: begin
                phase_d = PH_DRAIN;
                cnt_d   = '0;
            end
        endcase

        commit   = last_meas && (period_q == PERIOD_LAST);
        period_d = period_q;
        if (last_meas) begin
            period_d = commit ? '0 : period_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= PH_DRAIN;
            cnt_q    <= '0;
            period_q <= '0;
            drain_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            drain_q  <= (phase_d == PH_DRAIN);
            valid_q  <= commit;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        measure_channel #(
            .VALUE_W  (VALUE_W),
            .DEBOUNCE (DEBOUNCE),
            .AVG_LOG2 (AVG_LOG2)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .measure_i     (measure[i]),
            .meas_active_i (phase_q == PH_MEASURE),
            .start_i       (start_meas),
            .last_i        (last_meas),
            .commit_i      (commit),
            .raw_sample_i  (cnt_q[CNT_W-2 -: VALUE_W]),
            .value_o       (value[i*VALUE_W +: VALUE_W]),
            .timeout_o     (timeout[i])
        );
    end

    assign drain_capacitance = drain_q;
    assign value_valid       = valid_q;

endmodule
